mem_stage: RTL and testbench

- RV32I memory-access stage. Sits between the EX/MEM pipeline register and write-back.
- Takes the address, store data and control from EX/MEM and runs a req/ack transaction with variable-latency data memory.
- Aligns store data, and aligns and extends load data.
- Holds the pipeline while memory is busy. Registers results into a MEM/WB boundary.

---
 rtl/riscv_pkg.sv | 22 ++
 rtl/load_store_align.sv | 76 +++++++
 rtl/mem_stage.sv | 163 ++++++++++++++++
 tb/tb_mem_stage.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I definitions used by the memory-access stage.
//   F3_*      : funct3 codes for load/store size and signedness
//   mem_state_t : memory-stage FSM states
//   WB_*      : write-back source select encodings
package riscv_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [0:0] {
    MS_IDLE = 1'b0,
    MS_WAIT = 1'b1
  } mem_state_t;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

endpackage

// File: rtl/load_store_align.sv
// Byte-lane steering for the memory stage (purely combinational).
//   addr_lo_i    : effective address bits [1:0]
//   funct3_i     : access size / signedness
//   store_data_i : rs2 value to be stored
//   rdata_i      : word returned by data memory
//   be_o         : byte enables for a store of this size at this offset
//   wdata_o      : store data replicated into every lane of its size
//   load_data_o  : selected, sign/zero-extended load result
//   misaligned_o : access size does not fit the address alignment
module load_store_align
  import riscv_pkg::*;
(
  input  logic [1:0]  addr_lo_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] store_data_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] load_data_o,
  output logic        misaligned_o
);

  logic [31:0]        rdata_shifted;
  logic signed [7:0]  ld_byte;
  logic signed [15:0] ld_half;

  // Bring the addressed byte/half down to bit 0 before extension.
  assign rdata_shifted = rdata_i >> {addr_lo_i, 3'b000};
  assign ld_byte       = rdata_shifted[7:0];
  assign ld_half       = rdata_shifted[15:0];

  always_comb begin
    load_data_o = '0;
    case (funct3_i)
      F3_B:    load_data_o = 32'(ld_byte);
      F3_H:    load_data_o = 32'(ld_half);
      F3_W:    load_data_o = rdata_shifted;
      F3_BU:   load_data_o = {24'h0, rdata_shifted[7:0]};
      F3_HU:   load_data_o = {16'h0, rdata_shifted[15:0]};
      default: load_data_o = '0;
    endcase
  end

  // Replicating the data lets memory pick it up from whichever lane is enabled.
  always_comb begin
    be_o    = 4'b0000;
    wdata_o = store_data_i;
    case (funct3_i[1:0])
      2'b00: begin
        be_o    = 4'b0001 << addr_lo_i;
        wdata_o = {4{store_data_i[7:0]}};
      end
      2'b01: begin
        be_o    = 4'b0011 << {addr_lo_i[1], 1'b0};
        wdata_o = {2{store_data_i[15:0]}};
      end
      2'b10: begin
        be_o    = 4'b1111;
        wdata_o = store_data_i;
      end
      default: begin
        be_o    = 4'b0000;
        wdata_o = store_data_i;
      end
    endcase
  end

  always_comb begin
    case (funct3_i[1:0])
      2'b01:   misaligned_o = addr_lo_i[0];
      2'b10:   misaligned_o = |addr_lo_i;
      default: misaligned_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// RV32I memory-access stage: req/ack data-memory transaction, pipeline hold
// while memory is busy, wait-state timeout, and the MEM/WB register.
//   clk, rst            : clock, asynchronous active-high reset
//   pc_in .. reg_write_in : instruction fields from EX/MEM
//   dmem_*              : data-memory request side (ack/rdata come back)
//   mem_stall           : freeze upstream stages this cycle
//   misaligned          : current access violates its size alignment
//   wb_*                : registered MEM/WB outputs
module mem_stage
  import riscv_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_in,
  input  logic [31:0] alu_result_in,
  input  logic [31:0] rs2_data_in,
  input  logic [2:0]  funct3_in,
  input  logic [4:0]  rd_in,
  input  logic [1:0]  wb_sel_in,
  input  logic        mem_read_in,
  input  logic        mem_write_in,
  input  logic        reg_write_in,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        mem_stall,
  output logic        misaligned,
  output logic [31:0] wb_pc,
  output logic [31:0] wb_alu_result,
  output logic [31:0] wb_load_data,
  output logic [4:0]  wb_rd,
  output logic [1:0]  wb_sel,
  output logic        wb_reg_write,
  output logic        wb_valid,
  output logic        wb_bus_err,
  output logic        wb_misaligned
);

  localparam bit               TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] TO_LAST = TO_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  mem_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic        access, is_store, is_load;
  logic        align_bad, misaligned_acc, timeout_hit, req;
  logic [3:0]  be_raw;
  logic [31:0] wdata_raw, ld_data;

  logic [31:0] wb_pc_q, wb_alu_result_q, wb_load_data_q;
  logic [4:0]  wb_rd_q;
  logic [1:0]  wb_sel_q;
  logic        wb_reg_write_q, wb_valid_q, wb_bus_err_q, wb_misaligned_q;

  load_store_align u_align (
    .addr_lo_i    (alu_result_in[1:0]),
    .funct3_i     (funct3_in),
    .store_data_i (rs2_data_in),
    .rdata_i      (dmem_rdata),
    .be_o         (be_raw),
    .wdata_o      (wdata_raw),
    .load_data_o  (ld_data),
    .misaligned_o (align_bad)
  );

  // A request with both read and write set is a store.
  assign access         = mem_read_in | mem_write_in;
  assign is_store       = mem_write_in;
  assign is_load        = mem_read_in & ~mem_write_in;
  assign misaligned_acc = access & align_bad;
  assign misaligned     = misaligned_acc;

  // Last permitted wait cycle with no ack: retire with a bus error instead.
  assign timeout_hit = TO_EN && (state_q == MS_WAIT) && !dmem_ack && (cnt_q == TO_LAST);

  // Request is combinational so a same-cycle ack costs no extra cycles;
  // gating with rst drops it immediately when reset hits mid-transaction.
  assign req = ~rst & (((state_q == MS_IDLE) & access & ~align_bad) | (state_q == MS_WAIT));

  assign dmem_req   = req;
  assign dmem_we    = ~rst & is_store;
  assign dmem_be    = (~rst & is_store) ? be_raw : 4'b0000;
  assign dmem_wdata = wdata_raw;
  assign dmem_addr  = {alu_result_in[31:2], 2'b00};
  assign mem_stall  = req & ~dmem_ack & ~timeout_hit;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      MS_IDLE: begin
        if (req && !dmem_ack) begin
          state_d = MS_WAIT;
          cnt_d   = '0;
        end
      end
      MS_WAIT: begin
        if (dmem_ack || timeout_hit) begin
          state_d = MS_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = MS_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= MS_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // MEM/WB boundary: capture when not stalled, otherwise emit a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_pc_q         <= '0;
      wb_alu_result_q <= '0;
      wb_load_data_q  <= '0;
      wb_rd_q         <= '0;
      wb_sel_q        <= '0;
      wb_reg_write_q  <= 1'b0;
      wb_valid_q      <= 1'b0;
      wb_bus_err_q    <= 1'b0;
      wb_misaligned_q <= 1'b0;
    end else if (!mem_stall) begin
      wb_pc_q         <= pc_in;
      wb_alu_result_q <= alu_result_in;
      wb_load_data_q  <= is_load ? ld_data : '0;
      wb_rd_q         <= rd_in;
      wb_sel_q        <= wb_sel_in;
      wb_reg_write_q  <= reg_write_in & ~misaligned_acc & ~timeout_hit;
      wb_valid_q      <= 1'b1;
      wb_bus_err_q    <= timeout_hit;
      wb_misaligned_q <= misaligned_acc;
    end else begin
      wb_valid_q      <= 1'b0;
      wb_reg_write_q  <= 1'b0;
    end
  end

  assign wb_pc         = wb_pc_q;
  assign wb_alu_result = wb_alu_result_q;
  assign wb_load_data  = wb_load_data_q;
  assign wb_rd         = wb_rd_q;
  assign wb_sel        = wb_sel_q;
  assign wb_reg_write  = wb_reg_write_q;
  assign wb_valid      = wb_valid_q;
  assign wb_bus_err    = wb_bus_err_q;
  assign wb_misaligned = wb_misaligned_q;

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;
  import riscv_pkg::*;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_in, alu_result_in, rs2_data_in;
  logic [2:0]  funct3_in;
  logic [4:0]  rd_in;
  logic [1:0]  wb_sel_in;
  logic        mem_read_in, mem_write_in, reg_write_in;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        mem_stall, misaligned;
  logic [31:0] wb_pc, wb_alu_result, wb_load_data;
  logic [4:0]  wb_rd;
  logic [1:0]  wb_sel;
  logic        wb_reg_write, wb_valid, wb_bus_err, wb_misaligned;

  // Bench-side memory: acks once the access has waited 'lat' cycles (-1 = never).
  int          lat;
  int          n;
  logic        spur;
  logic [31:0] mem_word;
  assign dmem_rdata = mem_word;
  assign dmem_ack   = spur | (dmem_req && (lat >= 0) && (n == lat));

  int n_vec = 0;
  int n_bad = 0;

  logic [3:0]  cap_be;
  logic [31:0] cap_wdata;
  logic        cap_req, cap_mis;

  always #5 clk = ~clk;

  mem_stage #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .pc_in(pc_in), .alu_result_in(alu_result_in), .rs2_data_in(rs2_data_in),
    .funct3_in(funct3_in), .rd_in(rd_in), .wb_sel_in(wb_sel_in),
    .mem_read_in(mem_read_in), .mem_write_in(mem_write_in), .reg_write_in(reg_write_in),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata), .mem_stall(mem_stall), .misaligned(misaligned),
    .wb_pc(wb_pc), .wb_alu_result(wb_alu_result), .wb_load_data(wb_load_data),
    .wb_rd(wb_rd), .wb_sel(wb_sel), .wb_reg_write(wb_reg_write),
    .wb_valid(wb_valid), .wb_bus_err(wb_bus_err), .wb_misaligned(wb_misaligned)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (byte-level view of the access) -------
  function automatic int size_of(input logic [2:0] f3);
    case (f3[1:0])
      2'b01:   return 2;
      2'b10:   return 4;
      default: return 1;
    endcase
  endfunction

  function automatic logic [3:0] exp_be_f(input logic [31:0] a, input logic [2:0] f3);
    logic [3:0] be;
    int off, sz;
    off = int'(a[1:0]);
    sz  = size_of(f3);
    for (int k = 0; k < 4; k++) be[k] = (k >= off) && (k < off + sz);
    return be;
  endfunction

  function automatic logic [31:0] exp_wdata_f(input logic [31:0] sd, input logic [2:0] f3);
    logic [31:0] w;
    int sz;
    sz = size_of(f3);
    for (int k = 0; k < 4; k++) w[8*k +: 8] = sd[8*(k % sz) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] exp_load_f(input logic [31:0] w, input logic [31:0] a,
                                             input logic [2:0] f3);
    longint v;
    int off, sz;
    if (!(f3 == F3_B || f3 == F3_H || f3 == F3_W || f3 == F3_BU || f3 == F3_HU)) return 32'h0;
    off = int'(a[1:0]);
    sz  = size_of(f3);
    v   = 0;
    for (int i = 0; i < sz; i++)
      if (off + i < 4) v += longint'(w[8*(off+i) +: 8]) << (8*i);
    if (!f3[2] && sz < 4 && v >= (longint'(1) << (8*sz - 1))) v -= longint'(1) << (8*sz);
    return 32'(v);
  endfunction

  logic e_acc, e_aln, e_req, e_ack, e_to, e_stall;
  always_comb begin
    e_acc   = mem_read_in | mem_write_in;
    e_aln   = (int'(alu_result_in[1:0]) % size_of(funct3_in)) == 0;
    e_req   = !rst && e_acc && e_aln;
    e_ack   = e_req && (lat >= 0) && (n == lat);
    e_to    = e_req && !e_ack && (n == TO);
    e_stall = e_req && !e_ack && !e_to;
  end

  logic [31:0] m_pc, m_alu, m_ld;
  logic [4:0]  m_rd;
  logic [1:0]  m_sel;
  logic        m_rw, m_valid, m_err, m_mis;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pc <= '0; m_alu <= '0; m_ld <= '0; m_rd <= '0; m_sel <= '0;
      m_rw <= 1'b0; m_valid <= 1'b0; m_err <= 1'b0; m_mis <= 1'b0;
    end else if (!e_stall) begin
      m_pc    <= pc_in;
      m_alu   <= alu_result_in;
      m_rd    <= rd_in;
      m_sel   <= wb_sel_in;
      m_ld    <= (mem_read_in && !mem_write_in) ?
                 exp_load_f(mem_word, alu_result_in, funct3_in) : 32'h0;
      m_rw    <= reg_write_in && !(e_acc && !e_aln) && !e_to;
      m_valid <= 1'b1;
      m_err   <= e_to;
      m_mis   <= e_acc && !e_aln;
    end else begin
      m_valid <= 1'b0;
      m_rw    <= 1'b0;
    end
  end

  always @(negedge clk) begin
    chk("dmem_req", 32'(dmem_req), 32'(e_req));
    chk("mem_stall", 32'(mem_stall), 32'(e_stall));
    chk("misaligned", 32'(misaligned), 32'(e_acc && !e_aln));
    chk("dmem_we", 32'(dmem_we), 32'(!rst && mem_write_in));
    if (e_req) begin
      chk("dmem_addr", dmem_addr, alu_result_in & ~32'h3);
      chk("dmem_be", 32'(dmem_be),
          32'(mem_write_in ? exp_be_f(alu_result_in, funct3_in) : 4'b0000));
      if (mem_write_in) chk("dmem_wdata", dmem_wdata, exp_wdata_f(rs2_data_in, funct3_in));
    end
    chk("wb_pc", wb_pc, m_pc);
    chk("wb_alu_result", wb_alu_result, m_alu);
    chk("wb_load_data", wb_load_data, m_ld);
    chk("wb_rd", 32'(wb_rd), 32'(m_rd));
    chk("wb_sel", 32'(wb_sel), 32'(m_sel));
    chk("wb_reg_write", 32'(wb_reg_write), 32'(m_rw));
    chk("wb_valid", 32'(wb_valid), 32'(m_valid));
    chk("wb_bus_err", 32'(wb_bus_err), 32'(m_err));
    chk("wb_misaligned", 32'(wb_misaligned), 32'(m_mis));
  end

  // Present one instruction and hold it (as upstream would) until MEM releases it.
  task automatic apply(input logic [31:0] pc, input logic [31:0] a, input logic [31:0] sd,
                       input logic [2:0] f3, input logic [4:0] rdx, input logic rdm,
                       input logic wrm, input logic rw, input int l,
                       input logic [31:0] rdata, output int stalls);
    bit done;
    done = 1'b0;
    pc_in = pc; alu_result_in = a; rs2_data_in = sd; funct3_in = f3; rd_in = rdx;
    wb_sel_in = rdm ? WB_MEM : WB_ALU;
    mem_read_in = rdm; mem_write_in = wrm; reg_write_in = rw;
    lat = l; mem_word = rdata; n = 0; stalls = 0;
    for (int c = 0; c < 16 && !done; c++) begin
      @(negedge clk);
      if (c == 0) begin
        cap_be = dmem_be; cap_wdata = dmem_wdata; cap_req = dmem_req; cap_mis = misaligned;
      end
      if (!mem_stall) done = 1'b1;
      else stalls++;
      @(posedge clk); #1;
      if (!done) n++;
    end
    if (!done) begin
      n_vec++; n_bad++;
      $display("FAIL retire: pc %h still stalled after 16 cycles, expected release", pc);
    end
    mem_read_in = 1'b0; mem_write_in = 1'b0; reg_write_in = 1'b0; lat = -1; n = 0;
  endtask

  initial begin
    int st;
    rst = 1'b1; spur = 1'b0; lat = -1; n = 0; mem_word = '0;
    pc_in = '0; alu_result_in = '0; rs2_data_in = '0; funct3_in = '0; rd_in = '0;
    wb_sel_in = '0; mem_read_in = 1'b0; mem_write_in = 1'b0; reg_write_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset wb_valid", 32'(wb_valid), 32'h0);
    chk("reset wb_pc", wb_pc, 32'h0);
    chk("reset dmem_req", 32'(dmem_req), 32'h0);
    chk("reset mem_stall", 32'(mem_stall), 32'h0);
    chk("model lb", exp_load_f(32'h80AA55CC, 32'h103, F3_B), 32'hFFFFFF80);
    chk("model sh be", 32'(exp_be_f(32'h22, F3_H)), 32'hC);
    rst = 1'b0;
    @(posedge clk); #1;

    // SW, same-cycle ack
    apply(32'h40, 32'h100, 32'hDEADBEEF, F3_W, 5'd0, 1'b0, 1'b1, 1'b0, 0, 32'h0, st);
    chk("sw stalls", 32'(st), 32'd0);
    chk("sw be", 32'(cap_be), 32'hF);
    chk("sw wdata", cap_wdata, 32'hDEADBEEF);
    chk("sw wb_valid", 32'(wb_valid), 32'h1);
    chk("sw wb_pc", wb_pc, 32'h40);

    // LB / LBU, 3-cycle latency
    apply(32'h44, 32'h103, 32'h0, F3_B, 5'd5, 1'b1, 1'b0, 1'b1, 3, 32'h80AA55CC, st);
    chk("lb stalls", 32'(st), 32'd3);
    chk("lb data", wb_load_data, 32'hFFFFFF80);
    chk("lb reg_write", 32'(wb_reg_write), 32'h1);
    chk("lb rd", 32'(wb_rd), 32'd5);
    apply(32'h48, 32'h103, 32'h0, F3_BU, 5'd5, 1'b1, 1'b0, 1'b1, 3, 32'h80AA55CC, st);
    chk("lbu data", wb_load_data, 32'h00000080);

    // SH lanes
    apply(32'h4C, 32'h22, 32'h0000BEEF, F3_H, 5'd0, 1'b0, 1'b1, 1'b0, 1, 32'h0, st);
    chk("sh be", 32'(cap_be), 32'hC);
    chk("sh wdata", cap_wdata, 32'hBEEFBEEF);
    chk("sh stalls", 32'(st), 32'd1);

    // Misaligned LW
    apply(32'h50, 32'h101, 32'h0, F3_W, 5'd6, 1'b1, 1'b0, 1'b1, 0, 32'h11223344, st);
    chk("mis req", 32'(cap_req), 32'h0);
    chk("mis flag", 32'(cap_mis), 32'h1);
    chk("mis stalls", 32'(st), 32'd0);
    chk("mis wb_misaligned", 32'(wb_misaligned), 32'h1);
    chk("mis wb_reg_write", 32'(wb_reg_write), 32'h0);

    // Timeout with no ack, then an immediate-ack access proves the FSM is idle
    apply(32'h54, 32'h200, 32'h0, F3_W, 5'd7, 1'b1, 1'b0, 1'b1, -1, 32'h12345678, st);
    chk("to stalls", 32'(st), 32'd4);
    chk("to bus_err", 32'(wb_bus_err), 32'h1);
    chk("to reg_write", 32'(wb_reg_write), 32'h0);
    apply(32'h58, 32'h102, 32'h0, F3_H, 5'd8, 1'b1, 1'b0, 1'b1, 0, 32'h80010000, st);
    chk("lh stalls", 32'(st), 32'd0);
    chk("lh data", wb_load_data, 32'hFFFF8001);
    chk("lh bus_err", 32'(wb_bus_err), 32'h0);
    apply(32'h5C, 32'h102, 32'h0, F3_HU, 5'd8, 1'b1, 1'b0, 1'b1, 2, 32'h80010000, st);
    chk("lhu stalls", 32'(st), 32'd2);
    chk("lhu data", wb_load_data, 32'h00008001);
    apply(32'h60, 32'h104, 32'h0, F3_W, 5'd9, 1'b1, 1'b0, 1'b1, 1, 32'h0BADF00D, st);
    chk("lw data", wb_load_data, 32'h0BADF00D);
    apply(32'h64, 32'h100, 32'h0, 3'b110, 5'd9, 1'b1, 1'b0, 1'b1, 0, 32'hCAFEF00D, st);
    chk("unused f3 data", wb_load_data, 32'h0);

    // Spurious ack on a non-memory instruction
    spur = 1'b1;
    apply(32'h80, 32'h1234, 32'h0, 3'b000, 5'd9, 1'b0, 1'b0, 1'b1, -1, 32'h0, st);
    spur = 1'b0;
    chk("spur stalls", 32'(st), 32'd0);
    chk("spur alu", wb_alu_result, 32'h1234);
    chk("spur reg_write", 32'(wb_reg_write), 32'h1);

    // Reset in the middle of a wait
    pc_in = 32'h90; alu_result_in = 32'h300; funct3_in = F3_W; rd_in = 5'd10;
    wb_sel_in = WB_MEM; mem_read_in = 1'b1; mem_write_in = 1'b0; reg_write_in = 1'b1;
    lat = -1; n = 0;
    @(posedge clk); #1; n++;
    @(posedge clk); #1; n++;
    chk("pre-rst stall", 32'(mem_stall), 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("rst req", 32'(dmem_req), 32'h0);
    chk("rst stall", 32'(mem_stall), 32'h0);
    chk("rst wb_valid", 32'(wb_valid), 32'h0);
    chk("rst wb_pc", wb_pc, 32'h0);
    chk("rst wb_alu", wb_alu_result, 32'h0);
    pc_in = 32'h94; alu_result_in = 32'h5; rd_in = 5'd11; wb_sel_in = WB_ALU;
    mem_read_in = 1'b0; reg_write_in = 1'b1; n = 0;
    #3 rst = 1'b0;
    @(posedge clk); #1;
    chk("add alu", wb_alu_result, 32'h5);
    chk("add valid", 32'(wb_valid), 32'h1);
    chk("add rd", 32'(wb_rd), 32'd11);
    reg_write_in = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
